// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: default widths, timeout and
// the arbiter state encoding.
package mem_pkg;

    localparam int AW_DEF          = 16;
    localparam int DW_DEF          = 16;
    localparam int TIMEOUT_CYC_DEF = 64;
    localparam int CNT_W_DEF       = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_D_ISSUE = 3'd1,
        ST_D_WAIT  = 3'd2,
        ST_F_ISSUE = 3'd3,
        ST_F_WAIT  = 3'd4,
        ST_HALTED  = 3'd5,
        ST_ERR     = 3'd6
    } state_e;

    function automatic logic is_wait(input state_e s);
        return (s == ST_D_WAIT) || (s == ST_F_WAIT);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the arbiter.
// master = core/memory environment, slave = arbiter.
interface mem_port_arbiter_if
    import mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          halt;
    logic          m_busy;
    logic          m_done;
    logic [DW-1:0] m_rdata;

    logic          m_en;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          stall_if;
    logic          stall_mem;
    logic          halted;
    logic          err;

    modport master (
        output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, halt,
               m_busy, m_done, m_rdata,
        input  m_en, m_wr, m_addr, m_wdata, if_rdata, if_valid,
               d_rdata, d_valid, stall_if, stall_mem, halted, err
    );

    modport slave (
        input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, halt,
               m_busy, m_done, m_rdata,
        output m_en, m_wr, m_addr, m_wdata, if_rdata, if_valid,
               d_rdata, d_valid, stall_if, stall_mem, halted, err
    );

endinterface

// File: rtl/mem_port_arbiter_wait_timer.sv
// Saturating wait-cycle counter; expired flags the last permitted WAIT cycle.
module wait_timer
    import mem_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == CNT_EXP);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one stalling memory port between instruction fetch and data access,
// drives pipeline stalls and enforces HALT drain and sticky error.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic d_req;
    logic d_valid;
    logic if_valid;
    logic expired;
    logic m_en;

    assign d_req = bus.d_rd | bus.d_wr;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d  = state_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        d_valid  = 1'b0;
        if_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A data request, even one blocked by m_busy, outranks halt and fetch.
                if (d_req && bus.d_addr[0]) begin
                    state_d = ST_ERR;
                end else if (d_req) begin
                    if (!bus.m_busy) begin
                        state_d = ST_D_ISSUE;
                        addr_d  = bus.d_addr;
                        wr_d    = bus.d_wr;
                        wdata_d = bus.d_wdata;
                    end
                end else if (bus.halt) begin
                    state_d = ST_HALTED;
                end else if (bus.if_req && bus.if_addr[0]) begin
                    state_d = ST_ERR;
                end else if (bus.if_req && !bus.m_busy) begin
                    state_d = ST_F_ISSUE;
                    addr_d  = bus.if_addr;
                    wr_d    = 1'b0;
                end
            end
            ST_D_ISSUE: state_d = ST_D_WAIT;
            ST_F_ISSUE: state_d = ST_F_WAIT;
            ST_D_WAIT: begin
                if (bus.m_done) begin
                    d_valid = 1'b1;
                    state_d = ST_IDLE;
                end else if (expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_F_WAIT: begin
                if (bus.m_done) begin
                    if_valid = 1'b1;
                    state_d  = ST_IDLE;
                end else if (expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_HALTED, ST_ERR: state_d = state_q;
            default:           state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    // Counter runs only while staying in a WAIT state, so it reads 0 on entry.
    wait_timer #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!is_wait(state_d)),
        .inc     (is_wait(state_q)),
        .expired (expired)
    );

    assign m_en          = (state_q == ST_D_ISSUE) || (state_q == ST_F_ISSUE);
    assign bus.m_en      = m_en;
    assign bus.m_wr      = m_en & wr_q;
    assign bus.m_addr    = addr_q;
    assign bus.m_wdata   = wdata_q;
    assign bus.if_valid  = if_valid;
    assign bus.if_rdata  = if_valid ? bus.m_rdata : '0;
    assign bus.d_valid   = d_valid;
    assign bus.d_rdata   = (d_valid && !wr_q) ? bus.m_rdata : '0;
    assign bus.err       = (state_q == ST_ERR);
    assign bus.halted    = (state_q == ST_HALTED) || (state_q == ST_ERR);
    assign bus.stall_mem = d_req & ~d_valid & ~bus.err;
    assign bus.stall_if  = (bus.if_req & ~if_valid) | bus.stall_mem | bus.halted;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int TO = TIMEOUT_CYC_DEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if ifc ();

    mem_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    int          lat_min = 1, lat_max = 1, busy_pct = 0;
    bit          busy_force = 0, withhold = 0, noise_en = 0, fix_rdata_en = 0;
    logic [15:0] fix_rdata = '0;
    bit          en_seen = 0;

    always @(negedge clk) en_seen = ifc.m_en;

    initial begin
        bit          pend;
        int          cnt;
        logic [31:0] r;
        pend = 0;
        cnt  = 0;
        ifc.m_busy  = 1'b0;
        ifc.m_done  = 1'b0;
        ifc.m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (en_seen) begin
                pend = 1;
                cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
            end
            r = $urandom;
            ifc.m_rdata = fix_rdata_en ? fix_rdata : r[15:0];
            ifc.m_done  = 1'b0;
            if (pend) begin
                if (cnt > 0) cnt--;
                else if (!withhold) begin
                    ifc.m_done = 1'b1;
                    pend = 0;
                end
            end else if (noise_en && ($urandom_range(0, 7) == 0)) begin
                ifc.m_done = 1'b1;
            end
            ifc.m_busy = busy_force || (int'($urandom_range(0, 99)) < busy_pct);
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    // One outstanding access with its age in cycles: age 0 is the request
    // cycle, ages 1..TO are the response window.
    bit          md_act = 0, md_data = 0, md_wr = 0, md_halt = 0, md_err = 0;
    logic [15:0] md_addr = '0, md_wdata = '0;
    int          md_age = 0;

    always @(negedge clk) begin
        bit dreq, e_men, e_dv, e_iv, e_smem;
        if (rst) begin
            md_act = 0; md_halt = 0; md_err = 0; md_age = 0;
        end else begin
            dreq   = ifc.d_rd | ifc.d_wr;
            e_men  = md_act && (md_age == 0);
            e_dv   = md_act &&  md_data && (md_age >= 1) && ifc.m_done;
            e_iv   = md_act && !md_data && (md_age >= 1) && ifc.m_done;
            e_smem = dreq && !e_dv && !md_err;
            check("m_en",      ifc.m_en,      e_men);
            check("d_valid",   ifc.d_valid,   e_dv);
            check("if_valid",  ifc.if_valid,  e_iv);
            check("err",       ifc.err,       md_err);
            check("halted",    ifc.halted,    md_halt | md_err);
            check("stall_mem", ifc.stall_mem, e_smem);
            check("stall_if",  ifc.stall_if,  (ifc.if_req && !e_iv) || e_smem || md_halt || md_err);
            if (e_men) begin
                check("m_addr", ifc.m_addr, md_addr);
                check("m_wr",   ifc.m_wr,   md_data && md_wr);
                if (md_data && md_wr) check("m_wdata", ifc.m_wdata, md_wdata);
            end
            if (e_dv) check("d_rdata",  ifc.d_rdata,  md_wr ? 16'h0 : ifc.m_rdata);
            if (e_iv) check("if_rdata", ifc.if_rdata, ifc.m_rdata);

            if (md_act) begin
                if (md_age == 0)        md_age = 1;
                else if (ifc.m_done)    md_act = 0;
                else if (md_age == TO)  begin md_act = 0; md_err = 1; end
                else                    md_age++;
            end else if (!md_halt && !md_err) begin
                if (dreq) begin
                    if (ifc.d_addr[0]) md_err = 1;
                    else if (!ifc.m_busy) begin
                        md_act = 1; md_age = 0; md_data = 1;
                        md_wr = ifc.d_wr; md_addr = ifc.d_addr; md_wdata = ifc.d_wdata;
                    end
                end else if (ifc.halt) md_halt = 1;
                else if (ifc.if_req) begin
                    if (ifc.if_addr[0]) md_err = 1;
                    else if (!ifc.m_busy) begin
                        md_act = 1; md_age = 0; md_data = 0; md_wr = 0; md_addr = ifc.if_addr;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int wf_n;
    bit wf_stall_if_all, wf_men_any;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifc.if_req = 0; ifc.if_addr = '0; ifc.d_rd = 0; ifc.d_wr = 0;
        ifc.d_addr = '0; ifc.d_wdata = '0; ifc.halt = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // which: 0 m_en, 1 d_valid, 2 if_valid, 3 err. Returns at the hit negedge.
    task automatic wait_for(input string name, input int which, input int max);
        logic hit;
        hit = 1'b0;
        wf_n = -1;
        wf_stall_if_all = 1;
        wf_men_any = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = ifc.m_en;
                1:       hit = ifc.d_valid;
                2:       hit = ifc.if_valid;
                default: hit = ifc.err;
            endcase
            if (hit === 1'b1) begin
                wf_n = i;
                break;
            end
            wf_stall_if_all &= (ifc.stall_if === 1'b1);
            wf_men_any      |= (ifc.m_en === 1'b1);
        end
        check({name, "_seen"}, hit, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc, any, all, dv, iv;
        logic [31:0] r;
        logic [15:0] a;
        logic [1:0]  kind;

        do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("rst_ctrl",     {ifc.m_en, ifc.m_wr, ifc.if_valid, ifc.d_valid, ifc.halted, ifc.err}, 0);
        check("rst_m_addr",   ifc.m_addr, 0);
        check("rst_m_wdata",  ifc.m_wdata, 0);
        check("rst_if_rdata", ifc.if_rdata, 0);
        check("rst_d_rdata",  ifc.d_rdata, 0);
        tick();
        rst = 1'b0;

        // Fetch only
        lat_min = 1; lat_max = 1; fix_rdata_en = 1; fix_rdata = 16'hA5C3;
        tick();
        ifc.if_req = 1; ifc.if_addr = 16'h0010;
        wait_for("fetch_men", 0, 10);
        check("fetch_men_cycle", wf_n, 1);
        check("fetch_m_addr", ifc.m_addr, 16'h0010);
        check("fetch_m_wr", ifc.m_wr, 0);
        acc = wf_stall_if_all && ifc.stall_if;
        wait_for("fetch_valid", 2, 10);
        check("fetch_valid_cycle", wf_n, 0);
        check("fetch_rdata", ifc.if_rdata, 16'hA5C3);
        check("fetch_stall_hold", acc, 1);
        check("fetch_stall_release", ifc.stall_if, 0);
        tick();
        ifc.if_req = 0;

        // Contention: data first, then fetch
        fix_rdata_en = 0; lat_max = 2;
        tick();
        ifc.if_req = 1; ifc.if_addr = 16'h0004; ifc.d_rd = 1; ifc.d_addr = 16'h0200;
        wait_for("cont_men1", 0, 10);
        acc = wf_stall_if_all && ifc.stall_if;
        check("cont_addr1", ifc.m_addr, 16'h0200);
        wait_for("cont_dvalid", 1, 10);
        acc &= wf_stall_if_all && ifc.stall_if;
        tick();
        ifc.d_rd = 0;
        wait_for("cont_men2", 0, 10);
        acc &= wf_stall_if_all && ifc.stall_if;
        check("cont_addr2", ifc.m_addr, 16'h0004);
        wait_for("cont_ivalid", 2, 10);
        acc &= wf_stall_if_all;
        check("cont_stall_if", acc, 1);
        tick();
        ifc.if_req = 0;

        // Store while memory busy
        lat_max = 1;
        @(negedge clk);
        busy_force = 1;
        tick();
        ifc.d_wr = 1; ifc.d_addr = 16'h0100; ifc.d_wdata = 16'h1234;
        any = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            any |= ifc.m_en;
        end
        busy_force = 0;
        check("store_no_men_busy", any, 0);
        wait_for("store_men", 0, 10);
        check("store_men_cycle", wf_n, 1);
        check("store_m_wr", ifc.m_wr, 1);
        check("store_m_wdata", ifc.m_wdata, 16'h1234);
        wait_for("store_dvalid", 1, 10);
        check("store_d_rdata", ifc.d_rdata, 0);
        tick();
        ifc.d_wr = 0;

        // Halt drain
        lat_min = 3; lat_max = 3;
        tick();
        ifc.d_rd = 1; ifc.d_addr = 16'h0300;
        wait_for("halt_men", 0, 10);
        tick();
        ifc.halt = 1;
        wait_for("halt_dvalid", 1, 10);
        tick();
        ifc.d_rd = 0; ifc.if_req = 1; ifc.if_addr = 16'h0020;
        @(negedge clk);
        check("halt_not_yet", ifc.halted, 0);
        @(negedge clk);
        check("halt_set", ifc.halted, 1);
        any = 0; all = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            any |= ifc.m_en;
            all &= ifc.stall_if;
        end
        check("halt_no_men", any, 0);
        check("halt_stall_if", all, 1);
        do_reset();

        // Unaligned data address
        lat_min = 1; lat_max = 1;
        ifc.d_rd = 1; ifc.d_addr = 16'h0101;
        @(negedge clk);
        check("unal_err_not_yet", ifc.err, 0);
        any = ifc.m_en;
        @(negedge clk);
        check("unal_err", ifc.err, 1);
        check("unal_halted", ifc.halted, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            any |= ifc.m_en;
        end
        check("unal_no_men", any, 0);
        do_reset();

        // Timeout
        withhold = 1;
        ifc.d_rd = 1; ifc.d_addr = 16'h0040;
        wait_for("to_men", 0, 10);
        wait_for("to_err", 3, 100);
        check("to_err_cycle", wf_n, TO);
        check("to_halted", ifc.halted, 1);
        withhold = 0;
        any = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            any |= ifc.d_valid;
        end
        check("to_late_done_ignored", any, 0);
        do_reset();

        // Reset mid-access
        lat_min = 4; lat_max = 4; fix_rdata_en = 1; fix_rdata = 16'h5A5A;
        ifc.d_rd = 1; ifc.d_addr = 16'h0080;
        wait_for("rmid_men", 0, 10);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rmid_ctrl", {ifc.m_en, ifc.d_valid, ifc.halted, ifc.err}, 0);
        check("rmid_m_addr", ifc.m_addr, 0);
        ifc.d_rd = 0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        any = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            any |= ifc.d_valid | ifc.if_valid | ifc.m_en;
        end
        check("rmid_stale_ignored", any, 0);
        lat_min = 1; lat_max = 1;
        tick();
        ifc.if_req = 1; ifc.if_addr = 16'h0030;
        wait_for("rmid_fetch_men", 0, 10);
        check("rmid_fetch_addr", ifc.m_addr, 16'h0030);
        wait_for("rmid_fetch_valid", 2, 10);
        check("rmid_fetch_rdata", ifc.if_rdata, 16'h5A5A);
        tick();
        ifc.if_req = 0;
        fix_rdata_en = 0;

        // Randomized episodes
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            lat_min = 1; lat_max = 1 + (ep % 4); busy_pct = (ep % 3) * 20; noise_en = 1;
            for (int cy = 0; cy < 150; cy++) begin
                @(negedge clk);
                dv = ifc.d_valid;
                iv = ifc.if_valid;
                tick();
                if (dv || !(ifc.d_rd || ifc.d_wr)) begin
                    if ($urandom_range(0, 2) == 0) begin
                        r = $urandom;
                        kind = r[17:16];
                        a = r[15:0];
                        a[0] = (ep >= 5) && ($urandom_range(0, 40) == 0);
                        ifc.d_rd = (kind != 2'd1);
                        ifc.d_wr = (kind == 2'd1) || (kind == 2'd2);
                        ifc.d_addr = a;
                        ifc.d_wdata = r[31:16] ^ 16'h3C5A;
                    end else begin
                        ifc.d_rd = 0; ifc.d_wr = 0;
                    end
                end
                if (iv || !ifc.if_req) begin
                    if ($urandom_range(0, 1) == 0) begin
                        r = $urandom;
                        a = r[15:0];
                        a[0] = (ep >= 5) && ($urandom_range(0, 60) == 0);
                        ifc.if_req = 1;
                        ifc.if_addr = a;
                    end else begin
                        ifc.if_req = 0;
                    end
                end
                if (ep >= 4 && $urandom_range(0, 99) == 0) ifc.halt = 1;
            end
        end
        noise_en = 0; busy_pct = 0;
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported, stalling data/instruction memory between two requesters: instruction fetch (IF) and the data access issued by the decoded LD/ST/STU control (MemEnable/MemWr).
- Sequences each access through a request/done handshake with the memory.
- Generates pipeline stall signals and enforces HALT drain.
- Sits between the fetch/memory stages and the memory macro.

Parameters:
- AW, 16, address width in bits.
- DW, 16, data width in bits.
- TIMEOUT_CYC, 64, maximum WAIT cycles before error; must be ≥2.
- CNT_W, 7, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; level-held until if_valid.
- if_addr  in  AW  fetch address.
- d_rd  in  1  data read request (LD); level-held until d_valid.
- d_wr  in  1  data write request (ST/STU); level-held until d_valid.
- d_addr  in  AW  data address (ALU result).
- d_wdata  in  DW  store data.
- halt  in  1  HALT decoded.
- m_busy  in  1  memory cannot accept a request this cycle.
- m_done  in  1  memory completes the outstanding access; m_rdata valid.
- m_rdata  in  DW  memory read data.
- m_en  out  1  request strobe to memory; one cycle per access.
- m_wr  out  1  write qualifier; valid with m_en.
- m_addr  out  AW  request address; valid with m_en.
- m_wdata  out  DW  write data; valid with m_en.
- if_rdata  out  DW  fetched instruction; valid with if_valid.
- if_valid  out  1  fetch completes; one-cycle pulse.
- d_rdata  out  DW  load data; valid with d_valid.
- d_valid  out  1  data access completes; one-cycle pulse, reads and writes.
- stall_if  out  1  fetch stage must hold.
- stall_mem  out  1  memory stage and everything upstream must hold.
- halted  out  1  sticky; the core has stopped.
- err  out  1  sticky; unaligned access or timeout.

Behaviour:
- Reset: state IDLE, counter 0. m_en, m_wr, m_addr, m_wdata, if_valid, d_valid, if_rdata, d_rdata, halted, err all 0.
- States: IDLE, D_ISSUE, D_WAIT, F_ISSUE, F_WAIT, HALTED, ERR.
- IDLE, evaluated in this order:
  - d_rd|d_wr with d_addr[0]=1 → ERR.
  - d_rd|d_wr and !m_busy → D_ISSUE; data request latched.
  - halt → HALTED.
  - if_req with if_addr[0]=1 → ERR.
  - if_req and !m_busy → F_ISSUE.
  - Otherwise stay in IDLE.
- Priority: data beats fetch; halt beats fetch; a pending data access completes before HALTED.
- d_rd and d_wr both high is treated as write.
- D_ISSUE / F_ISSUE: registered m_en=1 for exactly one cycle with latched address, m_wr and wdata. Unconditional → D_WAIT / F_WAIT.
- D_WAIT / F_WAIT:
  - m_en=0. Counter increments each cycle.
  - m_done=1 → d_valid or if_valid = 1 combinationally that cycle. Data path: d_rdata = m_rdata on read, 0 on write. Fetch path: if_rdata = m_rdata. Then → IDLE with counter cleared.
  - counter == TIMEOUT_CYC-1 with no m_done → ERR.
- Minimum latency: request sampled at edge 1, m_en during cycle 1, m_done earliest in cycle 2, valid in cycle 2, IDLE at edge 3. Back-to-back accesses therefore cost 3 cycles each.
- m_done outside WAIT states (stale response after reset, or in IDLE, HALTED or ERR) is ignored.
- halt asserted during D_WAIT: finish the access, then HALTED (D_WAIT → IDLE → HALTED, data having priority as above).
- HALTED: halted=1, no m_en, all requests ignored. Exit only by reset.
- ERR: err=1, halted=1, no m_en. Exit only by reset.
- Stalls (combinational):
  - stall_mem = (d_rd|d_wr) & !d_valid & !err.
  - stall_if = (if_req & !if_valid) | stall_mem | halted.
- Reset mid-access: immediate return to IDLE. The memory's later m_done is ignored; no valid pulse.
- Width rules: addresses pass unmodified, with no arithmetic on them. The counter saturates; it never wraps.

Decomposition:
- Shared package mem_pkg:
  - State encoding localparams: ST_IDLE, ST_D_ISSUE, ST_D_WAIT, ST_F_ISSUE, ST_F_WAIT, ST_HALTED, ST_ERR.
  - AW and DW defaults.
  - Default TIMEOUT_CYC.
- One sub-module: wait_timer. Clear and increment inputs, saturating CNT_W counter, expired output at TIMEOUT_CYC-1.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0010, m_done 1 cycle after m_en with m_rdata=0xA5C3 → m_en one cycle with m_addr=0x0010, m_wr=0; if_valid pulse with if_rdata=0xA5C3 in cycle 2; stall_if high cycles 0–1.
- Contention: if_req and d_rd both asserted in cycle 0, d_addr=0x0200, if_addr=0x0004 → first m_en carries 0x0200; d_valid; then second m_en carries 0x0004; stall_if high until if_valid.
- Store: d_wr=1, d_addr=0x0100, d_wdata=0x1234, m_busy=1 for 3 cycles → no m_en while busy; then m_en with m_wr=1, m_wdata=0x1234; d_valid with d_rdata=0.
- Halt drain: halt asserted during D_WAIT → access completes with d_valid; halted=1 two cycles later; later if_req produces no m_en; stall_if=1.
- Errors, case 1: d_addr=0x0101 → err=1 next cycle; no m_en.
- Errors, case 2: m_done withheld for 64 cycles → err=1, halted=1; a late m_done produces no d_valid.
- Reset mid-op: rst pulsed in D_WAIT → all outputs 0 asynchronously; subsequent m_done ignored; new fetch serviced normally.
